cu_multicycle: RTL

- Parametrised multi-cycle successor to the single-cycle control unit.
- Accepts one opcode per valid/ready handshake and decodes the same four classes: data, mem, pc, vector.
- Holds the datapath control outputs for the required number of cycles: 1 for data/branch, until ack or timeout for memory, and one cycle per beat for vector ops.
- Owns the compare flag register and resolves conditional branches internally; sits between the fetch stage and the datapath/memory interface.

---
 rtl/cu_pkg.sv | 24 ++
 rtl/branch_resolve.sv | 23 ++
 rtl/cu_multicycle.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: instruction classes,
// FSM states and the sub-op / ALU constants used by decode.
package cu_pkg;

    typedef enum logic [1:0] {
        CLS_DATA = 2'b00,
        CLS_MEM  = 2'b01,
        CLS_PC   = 2'b10,
        CLS_VEC  = 2'b11
    } cls_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EXEC     = 2'b01,
        MEM_WAIT = 2'b10,
        VEC_RUN  = 2'b11
    } state_e;

    localparam logic [1:0] SUB_RST = 2'b00;
    localparam logic [1:0] SUB_INC = 2'b01;
    localparam logic [1:0] SUB_CMP = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b01;

endpackage

// File: rtl/branch_resolve.sv
// Compare-flag register and taken-branch equation; a conditional branch is
// taken only when the stored flag is set.
module branch_resolve (
    input  logic clk,
    input  logic reset,
    input  logic flag_we,
    input  logic flag_in,
    input  logic cond,
    output logic flag_q,
    output logic taken
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            flag_q <= 1'b0;
        end else if (flag_we) begin
            flag_q <= flag_in;
        end
    end

    assign taken = ~cond | flag_q;

endmodule

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: accepts one opcode per handshake and holds the
// datapath controls for one cycle (data/pc), until ack/timeout (mem) or per beat (vector).
module cu_multicycle
    import cu_pkg::*;
#(
    parameter  int OP_W        = 6,
    parameter  int ELEMS       = 16,
    parameter  int LANES       = 4,
    parameter  int MEM_TIMEOUT = 255,
    localparam int BEATS       = (ELEMS + LANES - 1) / LANES,
    localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   opcode,
    input  logic              flag_in,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_write,
    output logic              reg_write,
    output logic              pc_src,
    output logic              add1_sel,
    output logic              mem_sel,
    output logic              rst_out,
    output logic [1:0]        alu_control,
    output logic [1:0]        source,
    output logic [1:0]        mem_control,
    output logic [BEAT_W-1:0] lane_idx,
    output logic [LANES-1:0]  vec_mask,
    output logic              busy,
    output logic              flag_q,
    output logic              err
);

    localparam int LAST_N = ELEMS - (BEATS - 1) * LANES;
    localparam logic [LANES-1:0] LAST_MASK = {LANES{1'b1}} >> (LANES - LAST_N);
    localparam int TCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TLIM   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    state_e            state;
    logic [OP_W-1:0]   instr_q;
    logic [BEAT_W-1:0] beat;
    logic [TCNT_W-1:0] tcnt;

    cls_e       cls;
    logic [1:0] sub;
    logic       cond;
    logic       is_load;
    logic       accept;
    logic       last_beat;
    logic       timeout;
    logic       taken;
    logic       flag_we;
    logic       unused_rsvd;

    assign cls         = cls_e'(instr_q[4:3]);
    assign sub         = instr_q[2:1];
    assign cond        = instr_q[OP_W-1];
    assign is_load     = instr_q[0];
    // Reserved opcode bits are latched but never decoded.
    assign unused_rsvd = ^instr_q;

    assign accept    = instr_valid & instr_ready;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign timeout   = (MEM_TIMEOUT > 0) && (tcnt == TCNT_W'(TLIM));
    assign flag_we   = reset && (state == EXEC) && (cls == CLS_DATA) && (sub == SUB_CMP);

    branch_resolve u_branch (
        .clk     (clk),
        .reset   (reset),
        .flag_we (flag_we),
        .flag_in (flag_in),
        .cond    (cond),
        .flag_q  (flag_q),
        .taken   (taken)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            instr_q <= '0;
            beat    <= '0;
            tcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr_q <= opcode;
                        beat    <= '0;
                        tcnt    <= '0;
                        case (cls_e'(opcode[4:3]))
                            CLS_MEM: state <= MEM_WAIT;
                            CLS_VEC: state <= VEC_RUN;
                            default: state <= EXEC;
                        endcase
                    end
                end
                EXEC: state <= IDLE;
                MEM_WAIT: begin
                    // An ack in the final timeout cycle still completes normally.
                    if (mem_ack || timeout) begin
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                VEC_RUN: begin
                    if (last_beat) begin
                        beat  <= '0;
                        state <= IDLE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced to the idle pattern (but not ready) while reset is held.
    always_comb begin
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        pc_src      = 1'b0;
        add1_sel    = 1'b0;
        mem_sel     = 1'b0;
        rst_out     = 1'b0;
        err         = 1'b0;
        alu_control = ALU_ADD;
        source      = 2'b00;
        mem_control = 2'b00;
        lane_idx    = '0;
        vec_mask    = '0;
        if (reset) begin
            case (state)
                IDLE: instr_ready = 1'b1;
                EXEC: begin
                    source = cls;
                    if (cls == CLS_PC) begin
                        pc_src = taken;
                    end else begin
                        alu_control = sub;
                        reg_write   = (sub != SUB_CMP);
                        add1_sel    = (sub == SUB_INC);
                        rst_out     = (sub == SUB_RST);
                    end
                end
                MEM_WAIT: begin
                    source      = cls;
                    mem_req     = 1'b1;
                    mem_sel     = 1'b1;
                    mem_control = sub;
                    mem_write   = ~is_load;
                    reg_write   = is_load & mem_ack;
                    err         = timeout & ~mem_ack;
                end
                VEC_RUN: begin
                    source      = cls;
                    reg_write   = 1'b1;
                    alu_control = sub;
                    lane_idx    = beat;
                    vec_mask    = last_beat ? LAST_MASK : {LANES{1'b1}};
                end
                default: ;
            endcase
        end
    end

    assign busy = ~instr_ready;

endmodule
